// File: rtl/multicycle_core_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states, flag bit
// positions and instruction field extraction helpers.
package multicycle_core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_BZ  = 4'hC;
    localparam logic [3:0] OP_BN  = 4'hD;

    // Bit positions inside the {N,Z,C} flag vector.
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    function automatic logic [3:0] f_op(input logic [15:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [3:0] f_rd(input logic [15:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [3:0] f_ra(input logic [15:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [3:0] f_rb(input logic [15:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic [7:0] f_imm8(input logic [15:0] ir);
        return ir[7:0];
    endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Memory request/acknowledge bus between the core (master) and memory (slave).
interface multicycle_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/multicycle_core_regfile.sv
// 16-entry register file: two operand read ports plus a debug read port,
// one synchronous write port, synchronous active-low clear of every entry.
module multicycle_core_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        ra1,
    input  logic [3:0]        ra2,
    input  logic [3:0]        dbg_ra,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] dbg_rd
);

    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];

    // Next register contents: copy current state, overlay the single write.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d[waddr] = regs_q[waddr];
        end
    end

    // Register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads come straight from the flops, so a same-cycle write is not visible.
    assign rd1    = regs_q[ra1];
    assign rd2    = regs_q[ra2];
    assign dbg_rd = regs_q[dbg_ra];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle processor: FETCH/DECODE/EXEC/MEM/HALT control, inline ALU with
// {N,Z,C} flags, PC, and a req/ack memory master that tolerates wait states.
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    multicycle_core_if.master    mem,
    input  logic [3:0]           dbg_ra,
    output logic [DATA_W-1:0]    dbg_rd,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [2:0]           flags,
    output logic                 halted
);

    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        flags_q, flags_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              halted_q, halted_d;

    logic              rf_we_s;
    logic [3:0]        rf_waddr_s;
    logic [DATA_W-1:0] rf_wdata_s;
    logic [3:0]        rf_ra1_s;
    logic [3:0]        rf_ra2_s;
    logic [DATA_W-1:0] rf_rd1_s;
    logic [DATA_W-1:0] rf_rd2_s;

    logic [3:0]        op_s, rd_s, ra_s, rb_s;
    logic [7:0]        imm8_s;
    logic [DATA_W-1:0] ldi_val_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_c_s;
    logic              alu_op_s;

    assign op_s      = f_op(ir_q);
    assign rd_s      = f_rd(ir_q);
    assign ra_s      = f_ra(ir_q);
    assign rb_s      = f_rb(ir_q);
    assign imm8_s    = f_imm8(ir_q);
    assign ldi_val_s = {{(DATA_W-8){imm8_s[7]}}, imm8_s};

    multicycle_core_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk    (clk),
        .clr_n  (reset),
        .we     (rf_we_s),
        .waddr  (rf_waddr_s),
        .wdata  (rf_wdata_s),
        .ra1    (rf_ra1_s),
        .ra2    (rf_ra2_s),
        .dbg_ra (dbg_ra),
        .rd1    (rf_rd1_s),
        .rd2    (rf_rd2_s),
        .dbg_rd (dbg_rd)
    );

    // ALU on the latched operands; alu_op_s marks ops that update the flags.
    always_comb begin
        sum_s     = {1'b0, a_q} + {1'b0, b_q};
        diff_s    = {1'b0, a_q} - {1'b0, b_q};
        alu_res_s = ZERO_D;
        alu_c_s   = 1'b0;
        alu_op_s  = 1'b0;
        case (op_s)
            OP_ADD: begin
                alu_res_s = sum_s[DATA_W-1:0];
                alu_c_s   = sum_s[DATA_W];
                alu_op_s  = 1'b1;
            end
            OP_SUB: begin
                // Carry means "no borrow", i.e. ra >= rb unsigned.
                alu_res_s = diff_s[DATA_W-1:0];
                alu_c_s   = ~diff_s[DATA_W];
                alu_op_s  = 1'b1;
            end
            OP_AND: begin
                alu_res_s = a_q & b_q;
                alu_op_s  = 1'b1;
            end
            OP_OR: begin
                alu_res_s = a_q | b_q;
                alu_op_s  = 1'b1;
            end
            OP_XOR: begin
                alu_res_s = a_q ^ b_q;
                alu_op_s  = 1'b1;
            end
            OP_SHL: begin
                alu_res_s = {a_q[DATA_W-2:0], 1'b0};
                alu_c_s   = a_q[DATA_W-1];
                alu_op_s  = 1'b1;
            end
            OP_SHR: begin
                alu_res_s = {1'b0, a_q[DATA_W-1:1]};
                alu_c_s   = a_q[0];
                alu_op_s  = 1'b1;
            end
            default: begin
                alu_res_s = ZERO_D;
                alu_c_s   = 1'b0;
                alu_op_s  = 1'b0;
            end
        endcase
    end

    // Control FSM: next state, datapath register updates and memory requests.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        flags_d    = flags_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        halted_d   = halted_q;
        rf_we_s    = 1'b0;
        rf_waddr_s = rd_s;
        rf_wdata_s = alu_res_s;
        rf_ra1_s   = ra_s;
        rf_ra2_s   = rb_s;

        case (state_q)
            ST_FETCH: begin
                if (req_q) begin
                    // An outstanding request always completes, even if run dropped.
                    if (mem.mem_ack) begin
                        ir_d    = mem.mem_rdata[15:0];
                        pc_d    = pc_q + ONE_A;
                        req_d   = 1'b0;
                        state_d = ST_DECODE;
                    end else begin
                        req_d = 1'b1;
                    end
                end else if (run) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else begin
                    req_d = 1'b0;
                end
            end

            ST_DECODE: begin
                a_d     = rf_rd1_s;
                b_d     = rf_rd2_s;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                // Port 1 reads rd here so a store can capture its data.
                rf_ra1_s = rd_s;
                state_d  = ST_FETCH;
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                        rf_we_s         = alu_op_s;
                        rf_wdata_s      = alu_res_s;
                        flags_d[FLAG_N] = alu_res_s[DATA_W-1];
                        flags_d[FLAG_Z] = (alu_res_s == ZERO_D);
                        flags_d[FLAG_C] = alu_c_s;
                    end
                    OP_LDI: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = ldi_val_s;
                    end
                    OP_LD, OP_ST: begin
                        req_d   = 1'b1;
                        we_d    = (op_s == OP_ST);
                        addr_d  = a_q[ADDR_W-1:0];
                        wdata_d = rf_rd1_s;
                        state_d = ST_MEM;
                    end
                    OP_JMP: begin
                        pc_d = b_q[ADDR_W-1:0];
                    end
                    OP_BZ: begin
                        if (flags_q[FLAG_Z]) begin
                            pc_d = b_q[ADDR_W-1:0];
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_BN: begin
                        if (flags_q[FLAG_N]) begin
                            pc_d = b_q[ADDR_W-1:0];
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_NOP: begin
                        state_d = ST_FETCH;
                    end
                    default: begin
                        // Opcodes E and F halt the core.
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                endcase
            end

            ST_MEM: begin
                if (req_q && mem.mem_ack) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    rf_we_s    = (op_s == OP_LD);
                    rf_wdata_s = mem.mem_rdata;
                    state_d    = ST_FETCH;
                end else begin
                    req_d = req_q;
                end
            end

            ST_HALT: begin
                halted_d = 1'b1;
                req_d    = 1'b0;
                state_d  = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            a_q      <= ZERO_D;
            b_q      <= ZERO_D;
            flags_q  <= 3'b000;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= ZERO_A;
            wdata_q  <= ZERO_D;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            flags_q  <= flags_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign pc_out        = pc_q;
    assign flags         = flags_q;
    assign halted        = halted_q;

endmodule
